// File: rtl/glb_core_rd_xbar.sv
// glb_core_rd_xbar
//   Read-request crossbar for a GLB tile: NUM_CH requesters onto NUM_BANKS banks.
//   Each bank arbitrates its candidates (fixed priority or round-robin) and
//   losers are back-pressured through rdrq_ready. A per-bank tag pipeline of
//   depth RD_LATENCY remembers which channel issued each bank read so the
//   returning data is steered back to that channel one cycle later.
//   Requests whose tile field differs from glb_tile_id are consumed without
//   any bank access or response.
//   Optional feature: define GLB_RD_XBAR_PERF_CNT_EN to add per-channel
//   saturating counters of accepted bank-bound requests (perf_grant_cnt).
//   Tile-field bits that fall above the top of the address are read as zero.

module glb_core_rd_xbar #(
   parameter int NUM_CH          = 4,
   parameter int NUM_BANKS       = 2,
   parameter int ADDR_WIDTH      = 22,
   parameter int BANK_ADDR_WIDTH = 17,
   parameter int TILE_SEL_WIDTH  = 5,
   parameter int DATA_WIDTH      = 64,
   parameter int RD_LATENCY      = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [TILE_SEL_WIDTH-1:0]            glb_tile_id,
   input  logic                                 cfg_rr_en,
   input  logic [NUM_CH-1:0]                    cfg_ch_en,
   input  logic [NUM_CH-1:0]                    rdrq_valid,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]         rdrq_addr,
   output logic [NUM_CH-1:0]                    rdrq_ready,
   output logic [NUM_BANKS-1:0]                 bank_rd_en,
   output logic [NUM_BANKS*BANK_ADDR_WIDTH-1:0] bank_rd_addr,
   input  logic [NUM_BANKS-1:0]                 bank_rd_valid,
   input  logic [NUM_BANKS*DATA_WIDTH-1:0]      bank_rd_data,
   output logic [NUM_CH-1:0]                    rdrs_valid,
   output logic [NUM_CH*DATA_WIDTH-1:0]         rdrs_data,
   output logic                                 err_orphan
`ifdef GLB_RD_XBAR_PERF_CNT_EN
   ,
   output logic [NUM_CH*32-1:0]                 perf_grant_cnt
`endif
);

   localparam int BSEL_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TILE_LSB = BANK_ADDR_WIDTH + BSEL_W;

   // request decode
   logic [NUM_CH-1:0]          act_s;
   logic [NUM_CH-1:0]          tile_hit_s;
   logic [NUM_CH-1:0]          drop_s;
   logic [TILE_SEL_WIDTH-1:0]  tile_fld_s [NUM_CH];
   logic [BSEL_W-1:0]          bsel_s     [NUM_CH];
   logic [NUM_CH-1:0]          cand_s     [NUM_BANKS];

   // arbitration
   logic [NUM_BANKS-1:0]       gnt_vld_s;
   logic [CH_W-1:0]            gnt_ch_s   [NUM_BANKS];
   logic [CH_W-1:0]            rr_nxt_s   [NUM_BANKS];
   logic [BANK_ADDR_WIDTH-1:0] gnt_addr_s [NUM_BANKS];
   logic [NUM_CH-1:0]          ch_gnt_s;
   logic [CH_W-1:0]            rr_ptr_r   [NUM_BANKS];

   // issue stage and tag pipeline
   logic [CH_W-1:0]            bank_ch_r  [NUM_BANKS];
   logic                       tag_vld_r  [NUM_BANKS][RD_LATENCY];
   logic [CH_W-1:0]            tag_ch_r   [NUM_BANKS][RD_LATENCY];

   // response steering
   logic [NUM_CH-1:0]            rs_vld_nxt_s;
   logic [NUM_CH*DATA_WIDTH-1:0] rs_data_nxt_s;
   logic                         orphan_s;

   // Decode each channel's tile and bank fields into per-bank candidate masks.
   always_comb begin
      act_s      = '0;
      tile_hit_s = '0;
      drop_s     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         for (int t = 0; t < TILE_SEL_WIDTH; t++) begin
            int pos;
            int sel;
            pos = TILE_LSB + t;
            sel = (pos < ADDR_WIDTH) ? pos : 0;
            tile_fld_s[i][t] = (pos < ADDR_WIDTH) ? rdrq_addr[i*ADDR_WIDTH + sel] : 1'b0;
         end
         bsel_s[i]     = rdrq_addr[i*ADDR_WIDTH + BANK_ADDR_WIDTH +: BSEL_W];
         act_s[i]      = cfg_ch_en[i] & rdrq_valid[i];
         tile_hit_s[i] = (tile_fld_s[i] == glb_tile_id);
         drop_s[i]     = act_s[i] & ~tile_hit_s[i];
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cand_s[b][i] = act_s[i] & tile_hit_s[i] & (bsel_s[i] == BSEL_W'(b));
         end
      end
   end

   // Per-bank arbitration: first candidate found scanning from ch0 (fixed) or from the RR pointer.
   always_comb begin
      gnt_vld_s = '0;
      ch_gnt_s  = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         gnt_ch_s[b] = '0;
         for (int k = 0; k < NUM_CH; k++) begin
            int   idx;
            logic pick;
            idx  = cfg_rr_en ? ((int'(rr_ptr_r[b]) + k) % NUM_CH) : k;
            pick = ~gnt_vld_s[b] & cand_s[b][idx];
            gnt_ch_s[b]   = pick ? CH_W'(idx) : gnt_ch_s[b];
            ch_gnt_s[idx] = ch_gnt_s[idx] | pick;
            gnt_vld_s[b]  = gnt_vld_s[b] | pick;
         end
         rr_nxt_s[b]   = CH_W'((int'(gnt_ch_s[b]) + 1) % NUM_CH);
         gnt_addr_s[b] = gnt_vld_s[b] ?
                         rdrq_addr[int'(gnt_ch_s[b])*ADDR_WIDTH +: BANK_ADDR_WIDTH] :
                         {BANK_ADDR_WIDTH{1'b0}};
      end
   end

   // A request is consumed when its bank granted it or when it targets another tile.
   assign rdrq_ready = drop_s | ch_gnt_s;

   // Register bank commands; RR pointers only advance while round-robin is selected,
   // so toggling cfg_rr_en resumes from the pointer it left.
   always_ff @(posedge clk) begin
      if (reset) begin
         bank_rd_en   <= '0;
         bank_rd_addr <= '0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            bank_ch_r[b] <= '0;
            rr_ptr_r[b]  <= '0;
         end
      end else begin
         bank_rd_en <= gnt_vld_s;
         for (int b = 0; b < NUM_BANKS; b++) begin
            bank_rd_addr[b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] <= gnt_addr_s[b];
            bank_ch_r[b] <= gnt_ch_s[b];
            if (cfg_rr_en && gnt_vld_s[b]) begin
               rr_ptr_r[b] <= rr_nxt_s[b];
            end
         end
      end
   end

   // Tag shift registers track {valid, channel} alongside the bank read latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
               tag_vld_r[b][s] <= 1'b0;
               tag_ch_r[b][s]  <= '0;
            end
         end
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            for (int s = 1; s < RD_LATENCY; s++) begin
               tag_vld_r[b][s] <= tag_vld_r[b][s-1];
               tag_ch_r[b][s]  <= tag_ch_r[b][s-1];
            end
            tag_vld_r[b][0] <= bank_rd_en[b];
            tag_ch_r[b][0]  <= bank_ch_r[b];
         end
      end
   end

   // Steer each bank's returning data to the channel named by its tag; flag tag/valid disagreement.
   always_comb begin
      rs_vld_nxt_s  = '0;
      rs_data_nxt_s = '0;
      orphan_s      = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         orphan_s = orphan_s | (bank_rd_valid[b] ^ tag_vld_r[b][RD_LATENCY-1]);
         for (int i = 0; i < NUM_CH; i++) begin
            logic sel;
            sel = tag_vld_r[b][RD_LATENCY-1] & (tag_ch_r[b][RD_LATENCY-1] == CH_W'(i));
            rs_vld_nxt_s[i] = rs_vld_nxt_s[i] | sel;
            rs_data_nxt_s[i*DATA_WIDTH +: DATA_WIDTH] = rs_data_nxt_s[i*DATA_WIDTH +: DATA_WIDTH] |
               ({DATA_WIDTH{sel}} & bank_rd_data[b*DATA_WIDTH +: DATA_WIDTH]);
         end
      end
   end

   // Register responses and the sticky orphan flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdrs_valid <= '0;
         rdrs_data  <= '0;
         err_orphan <= 1'b0;
      end else begin
         rdrs_valid <= rs_vld_nxt_s;
         rdrs_data  <= rs_data_nxt_s;
         err_orphan <= err_orphan | orphan_s;
      end
   end

`ifdef GLB_RD_XBAR_PERF_CNT_EN
   // Count bank-bound grants per channel, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_grant_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_gnt_s[i] && (perf_grant_cnt[i*32 +: 32] != 32'hFFFF_FFFF)) begin
               perf_grant_cnt[i*32 +: 32] <= perf_grant_cnt[i*32 +: 32] + 32'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_glb_core_rd_xbar.sv
// Directed, table-driven bench for glb_core_rd_xbar with a fixed-latency bank model.
module tb_glb_core_rd_xbar;

   localparam int NUM_CH = 4;
   localparam int NUM_BANKS = 2;
   localparam int AW = 22;
   localparam int BAW = 17;
   localparam int TSW = 5;
   localparam int DW = 64;
   localparam int LAT = 4;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [TSW-1:0]           glb_tile_id;
   logic                     cfg_rr_en;
   logic [NUM_CH-1:0]        cfg_ch_en;
   logic [NUM_CH-1:0]        rdrq_valid;
   logic [NUM_CH*AW-1:0]     rdrq_addr;
   logic [NUM_CH-1:0]        rdrq_ready;
   logic [NUM_BANKS-1:0]     bank_rd_en;
   logic [NUM_BANKS*BAW-1:0] bank_rd_addr;
   logic [NUM_BANKS-1:0]     bank_rd_valid;
   logic [NUM_BANKS*DW-1:0]  bank_rd_data;
   logic [NUM_CH-1:0]        rdrs_valid;
   logic [NUM_CH*DW-1:0]     rdrs_data;
   logic                     err_orphan;
`ifdef GLB_RD_XBAR_PERF_CNT_EN
   logic [NUM_CH*32-1:0]     perf_grant_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   glb_core_rd_xbar #(
      .NUM_CH(NUM_CH), .NUM_BANKS(NUM_BANKS), .ADDR_WIDTH(AW), .BANK_ADDR_WIDTH(BAW),
      .TILE_SEL_WIDTH(TSW), .DATA_WIDTH(DW), .RD_LATENCY(LAT)
   ) dut (
`ifdef GLB_RD_XBAR_PERF_CNT_EN
      .perf_grant_cnt(perf_grant_cnt),
`endif
      .clk(clk), .reset(reset), .glb_tile_id(glb_tile_id), .cfg_rr_en(cfg_rr_en),
      .cfg_ch_en(cfg_ch_en), .rdrq_valid(rdrq_valid), .rdrq_addr(rdrq_addr),
      .rdrq_ready(rdrq_ready), .bank_rd_en(bank_rd_en), .bank_rd_addr(bank_rd_addr),
      .bank_rd_valid(bank_rd_valid), .bank_rd_data(bank_rd_data), .rdrs_valid(rdrs_valid),
      .rdrs_data(rdrs_data), .err_orphan(err_orphan)
   );

   // Bank model: returns data exactly LAT cycles after bank_rd_en; independent of DUT reset.
   logic           mdl_clr;
   logic           mdl_vld  [NUM_BANKS][LAT];
   logic [BAW-1:0] mdl_addr [NUM_BANKS][LAT];

   function automatic logic [DW-1:0] data_of(input int b, input logic [BAW-1:0] a);
      return {16'hDA7A, 16'(b), 15'h0, a};
   endfunction

   function automatic logic [AW-1:0] mk_addr(input logic [3:0] t, input logic b, input logic [BAW-1:0] o);
      return {t, b, o};
   endfunction

   always @(posedge clk) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         for (int s = LAT - 1; s > 0; s--) begin
            mdl_vld[b][s]  <= mdl_clr ? 1'b0 : mdl_vld[b][s-1];
            mdl_addr[b][s] <= mdl_clr ? '0 : mdl_addr[b][s-1];
         end
         mdl_vld[b][0]  <= mdl_clr ? 1'b0 : bank_rd_en[b];
         mdl_addr[b][0] <= mdl_clr ? '0 : bank_rd_addr[b*BAW +: BAW];
      end
   end

   always_comb begin
      bank_rd_valid = '0;
      bank_rd_data  = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_rd_valid[b] = mdl_vld[b][LAT-1];
         bank_rd_data[b*DW +: DW] = mdl_vld[b][LAT-1] ? data_of(b, mdl_addr[b][LAT-1]) : '0;
      end
   end

   typedef struct {
      logic [NUM_CH-1:0]    ch_en;
      logic [NUM_CH-1:0]    vld;
      logic [NUM_CH*AW-1:0] addr;
      logic [NUM_CH-1:0]    exp_rdy;
      logic [NUM_BANKS-1:0] exp_en;
      logic [BAW-1:0]       exp_a0;
      logic [BAW-1:0]       exp_a1;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [NUM_CH*DW-1:0] act, input logic [NUM_CH*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rdrq_valid = '0;
      rdrq_addr  = '0;
      repeat (n) cyc();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   logic [NUM_CH*DW-1:0] exp_d;
   logic [AW-1:0]        z22;

   initial begin
      z22 = '0;
      reset = 1'b1; mdl_clr = 1'b1; glb_tile_id = 5'd5; cfg_rr_en = 1'b0;
      cfg_ch_en = 4'hF; rdrq_valid = '0; rdrq_addr = '0;

      vecs[0] = '{4'hF, 4'b0001, {z22, z22, z22, mk_addr(4'd5, 1'b0, 17'h40)}, 4'b0001, 2'b01, 17'h40, 17'h0};
      vecs[1] = '{4'hF, 4'b1101, {mk_addr(4'd5, 1'b1, 17'h300), mk_addr(4'd5, 1'b1, 17'h200), z22,
                                  mk_addr(4'd5, 1'b1, 17'h100)}, 4'b0001, 2'b10, 17'h0, 17'h100};
      vecs[2] = '{4'hF, 4'b1100, {mk_addr(4'd5, 1'b1, 17'h300), mk_addr(4'd5, 1'b1, 17'h200), z22, z22},
                  4'b0100, 2'b10, 17'h0, 17'h200};
      vecs[3] = '{4'hF, 4'b1000, {mk_addr(4'd5, 1'b1, 17'h300), z22, z22, z22}, 4'b1000, 2'b10, 17'h0, 17'h300};
      vecs[4] = '{4'hF, 4'b0011, {z22, z22, mk_addr(4'd5, 1'b1, 17'h22), mk_addr(4'd5, 1'b0, 17'h11)},
                  4'b0011, 2'b11, 17'h11, 17'h22};
      vecs[5] = '{4'b1011, 4'b0101, {z22, mk_addr(4'd5, 1'b0, 17'h44), z22, mk_addr(4'd6, 1'b0, 17'h33)},
                  4'b0001, 2'b00, 17'h0, 17'h0};
      vecs[6] = '{4'hF, 4'b1111, {mk_addr(4'd5, 1'b0, 17'h4), mk_addr(4'd5, 1'b0, 17'h3),
                                  mk_addr(4'd5, 1'b0, 17'h2), mk_addr(4'd5, 1'b0, 17'h1)},
                  4'b0001, 2'b01, 17'h1, 17'h0};
      vecs[7] = '{4'hF, 4'b1011, {mk_addr(4'd5, 1'b1, 17'h66), z22, mk_addr(4'd5, 1'b0, 17'h55),
                                  mk_addr(4'd7, 1'b1, 17'h77)}, 4'b1011, 2'b11, 17'h55, 17'h66};
      vecs[8] = '{4'hF, 4'b0000, {z22, z22, z22, z22}, 4'b0000, 2'b00, 17'h0, 17'h0};
      vecs[9] = '{4'h0, 4'b1111, {mk_addr(4'd5, 1'b0, 17'h9), mk_addr(4'd5, 1'b1, 17'h8),
                                  mk_addr(4'd5, 1'b0, 17'h7), mk_addr(4'd5, 1'b1, 17'h6)},
                  4'b0000, 2'b00, 17'h0, 17'h0};

      // Reset state
      repeat (3) cyc();
      reset = 1'b0; mdl_clr = 1'b0;
      #1;
      chk("rst_bank_rd_en", 256'(bank_rd_en), 256'h0);
      chk("rst_bank_rd_addr", 256'(bank_rd_addr), 256'h0);
      chk("rst_rdrs_valid", 256'(rdrs_valid), 256'h0);
      chk("rst_rdrs_data", rdrs_data, 256'h0);
      chk("rst_err_orphan", 256'(err_orphan), 256'h0);
      cyc();

      // Single read: ch1 -> bank0 addr 0x40, response exactly 6 cycles after accept
      rdrq_valid = 4'b0010;
      rdrq_addr  = {z22, z22, mk_addr(4'd5, 1'b0, 17'h40), z22};
      #1;
      chk("lat_ready", 256'(rdrq_ready), 256'(4'b0010));
      cyc();
      rdrq_valid = '0;
      chk("lat_bank_en", 256'(bank_rd_en), 256'(2'b01));
      chk("lat_bank_addr0", 256'(bank_rd_addr[0 +: BAW]), 256'(17'h40));
      for (int k = 2; k <= 7; k++) begin
         cyc();
         chk($sformatf("lat_rdrs_valid_T%0d", k), 256'(rdrs_valid), (k == 6) ? 256'(4'b0010) : 256'h0);
         if (k == 6) begin
            exp_d = '0;
            exp_d[DW +: DW] = data_of(0, 17'h40);
            chk("lat_rdrs_data", rdrs_data, exp_d);
         end
      end
      chk("lat_no_orphan", 256'(err_orphan), 256'h0);

      // Table of single-cycle arbitration / decode vectors (fixed priority)
      for (int v = 0; v < 10; v++) begin
         cfg_ch_en  = vecs[v].ch_en;
         rdrq_valid = vecs[v].vld;
         rdrq_addr  = vecs[v].addr;
         #1;
         chk($sformatf("vec%0d_ready", v), 256'(rdrq_ready), 256'(vecs[v].exp_rdy));
         cyc();
         rdrq_valid = '0;
         chk($sformatf("vec%0d_bank_en", v), 256'(bank_rd_en), 256'(vecs[v].exp_en));
         if (vecs[v].exp_en[0]) chk($sformatf("vec%0d_addr0", v), 256'(bank_rd_addr[0 +: BAW]), 256'(vecs[v].exp_a0));
         if (vecs[v].exp_en[1]) chk($sformatf("vec%0d_addr1", v), 256'(bank_rd_addr[BAW +: BAW]), 256'(vecs[v].exp_a1));
      end
      cfg_ch_en = 4'hF;
      idle(10);
      chk("tbl_no_orphan", 256'(err_orphan), 256'h0);
      chk("tbl_quiet_rdrs", 256'(rdrs_valid), 256'h0);

      // Two banks in parallel: ch0 -> bank0, ch1 -> bank1
      rdrq_valid = 4'b0011;
      rdrq_addr  = {z22, z22, mk_addr(4'd5, 1'b1, 17'h456), mk_addr(4'd5, 1'b0, 17'h123)};
      #1;
      chk("par_ready", 256'(rdrq_ready), 256'(4'b0011));
      cyc();
      rdrq_valid = '0;
      chk("par_bank_en", 256'(bank_rd_en), 256'(2'b11));
      repeat (4) cyc();
      chk("par_rdrs_valid_T5", 256'(rdrs_valid), 256'h0);
      cyc();
      chk("par_rdrs_valid_T6", 256'(rdrs_valid), 256'(4'b0011));
      exp_d = '0;
      exp_d[0 +: DW]  = data_of(0, 17'h123);
      exp_d[DW +: DW] = data_of(1, 17'h456);
      chk("par_rdrs_data", rdrs_data, exp_d);
      idle(8);

      // Round-robin: ch0 and ch2 hold bank0 requests for 6 cycles
      do_reset();
      cfg_rr_en  = 1'b1;
      rdrq_valid = 4'b0101;
      rdrq_addr  = {z22, mk_addr(4'd5, 1'b0, 17'h20), z22, mk_addr(4'd5, 1'b0, 17'h10)};
      for (int k = 0; k < 6; k++) begin
         #1;
         chk($sformatf("rr_ready_%0d", k), 256'(rdrq_ready), (k % 2 == 0) ? 256'(4'b0001) : 256'(4'b0100));
         cyc();
      end
      rdrq_valid = 4'b1001;
      rdrq_addr  = {mk_addr(4'd5, 1'b0, 17'h30), z22, z22, mk_addr(4'd5, 1'b0, 17'h10)};
      #1;
      chk("rr_ptr_after", 256'(rdrq_ready), 256'(4'b1000));
      cyc();
      idle(10);
      cfg_rr_en = 1'b0;
      chk("rr_no_orphan", 256'(err_orphan), 256'h0);

      // Reset two cycles after accept: response suppressed, late bank data is an orphan
      rdrq_valid = 4'b0100;
      rdrq_addr  = {z22, mk_addr(4'd5, 1'b1, 17'h77), z22, z22};
      #1;
      chk("rst_mid_ready", 256'(rdrq_ready), 256'(4'b0100));
      cyc();
      rdrq_valid = '0;
      chk("rst_mid_bank_en", 256'(bank_rd_en), 256'(2'b10));
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("rst_mid_en_clr", 256'(bank_rd_en), 256'h0);
      chk("rst_mid_err_T3", 256'(err_orphan), 256'h0);
      for (int k = 4; k <= 7; k++) begin
         cyc();
         chk($sformatf("rst_mid_rdrs_T%0d", k), 256'(rdrs_valid), 256'h0);
         chk($sformatf("rst_mid_err_T%0d", k), 256'(err_orphan), (k >= 6) ? 256'h1 : 256'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
